// File: rtl/trig_gen_pkg.sv
// Shared definitions for the trigger pulse-train generator.
package trig_gen_pkg;

  // Default width of the period, high-time, pulse-count and status counters.
  localparam int unsigned CNT_W_DEF = 32;

  // Generator FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/trig_phase_timer.sv
// Loadable down-counter that measures the length of one HIGH or LOW phase.
// expired_c flags the last cycle of a phase (count = 1); the owner is expected
// to reload on that cycle. Without a load the count stops at zero.
module trig_phase_timer
  import trig_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             expired_c
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (value_q != '0) begin
      value_d = value_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o   = value_q;
  assign expired_c = (value_q == CNT_W'(1));

endmodule

// File: rtl/trigger_pulse_generator.sv
// Programmable trigger pulse-train generator. A start request in IDLE latches
// period / high time / pulse count and emits a burst of rectangular pulses on
// trigger_out. num_pulses = 0 runs until abort. All outputs are registered.
module trigger_pulse_generator
  import trig_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_time,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             trigger_out,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] pulses_sent
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] pulses_q, pulses_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expired;
  logic             cfg_ok;
  logic             last_pulse;

  // Phase timer: reloaded on every HIGH/LOW entry.
  trig_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value),
    .expired_c  (tmr_expired)
  );

  // A valid config needs at least one high and one low cycle per pulse.
  assign cfg_ok     = (high_time != '0) && (high_time < period);
  assign last_pulse = (num_q != '0) && (pulses_q == num_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    high_d       = high_q;
    num_d        = num_q;
    pulses_d     = pulses_q;
    trig_d       = 1'b0;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            period_d     = period;
            high_d       = high_time;
            num_d        = num_pulses;
            pulses_d     = CNT_W'(1);
            trig_d       = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = high_time;
            state_d      = ST_HIGH;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          tmr_load     = 1'b1;
          tmr_load_val = period_q - high_q;
          state_d      = ST_LOW;
        end else begin
          trig_d = 1'b1;
        end
      end

      ST_LOW: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          if (last_pulse) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pulses_d     = pulses_q + CNT_W'(1);
            trig_d       = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = high_q;
            state_d      = ST_HIGH;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, latched config and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      high_q    <= '0;
      num_q     <= '0;
      pulses_q  <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      high_q    <= high_d;
      num_q     <= num_d;
      pulses_q  <= pulses_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign trigger_out = trig_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign pulses_sent = pulses_q;

  // The pulse output and the completion strobes are never seen together with
  // an inconsistent busy flag.
  a_trig_busy : assert property (@(posedge clock) disable iff (!reset_n)
    trig_q |-> busy_q);
  a_done_idle : assert property (@(posedge clock) disable iff (!reset_n)
    done_q |-> !busy_q);
  a_cfg_idle : assert property (@(posedge clock) disable iff (!reset_n)
    cfg_err_q |-> !busy_q);
  // An active phase always has time left on the phase timer.
  a_timer_live : assert property (@(posedge clock) disable iff (!reset_n)
    (state_q != ST_IDLE) |-> (tmr_value != '0));

endmodule

// File: tb/tb_trigger_pulse_generator.sv
// Scoreboard bench for trigger_pulse_generator: stimulus queues expected
// rise/fall/done/cfg_err events with their cycle and pulses_sent value; a
// monitor pops and compares whenever the DUT shows such an event.
module tb_trigger_pulse_generator;

  localparam int unsigned CNT_W = 32;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] num_pulses;
  logic             trigger_out;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] pulses_sent;

  typedef enum int {EV_RISE, EV_FALL, EV_DONE, EV_CFG} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       ps;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  logic prev_trig = 1'b0;

  trigger_pulse_generator #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .period      (period),
    .high_time   (high_time),
    .num_pulses  (num_pulses),
    .trigger_out (trigger_out),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .pulses_sent (pulses_sent)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string nm, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endfunction

  function automatic void push(ev_kind_e k, int c, int p);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.ps   = p;
    exp_q.push_back(e);
  endfunction

  function automatic void push_burst(int s, int p, int h, int n);
    for (int i = 0; i < n; i++) begin
      push(EV_RISE, s + i * p, i + 1);
      push(EV_FALL, s + i * p + h, i + 1);
    end
    push(EV_DONE, s + n * p, n);
  endfunction

  // Compare one observed DUT event against the head of the scoreboard.
  function automatic void take(ev_kind_e k);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got unexpected %s @cyc %0d ps=%0d, expected none",
               k.name(), cyc, pulses_sent);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.cyc != cyc || e.ps != int'(pulses_sent)) begin
      n_err++;
      $display("FAIL event: got %s cyc=%0d ps=%0d, expected %s cyc=%0d ps=%0d",
               k.name(), cyc, pulses_sent, e.kind.name(), e.cyc, e.ps);
    end
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_trig = 1'b0;
    end else begin
      if (trigger_out && !prev_trig) take(EV_RISE);
      if (!trigger_out && prev_trig) take(EV_FALL);
      if (done) begin
        take(EV_DONE);
        chk("busy in done cycle", busy, 0);
      end
      if (cfg_err) take(EV_CFG);
      prev_trig = trigger_out;
    end
  end

  // Stimulus acts 1 time unit after the falling edge.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic kick(input int p, input int h, input int n, output int s);
    period     = CNT_W'(p);
    high_time  = CNT_W'(h);
    num_pulses = CNT_W'(n);
    start      = 1'b1;
    s          = cyc + 1;
  endtask

  int s;
  int s2;
  int cfg_tab[3][2] = '{'{5, 5}, '{0, 3}, '{10, 0}};

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    period     = '0;
    high_time  = '0;
    num_pulses = '0;
    step();
    step();
    chk("reset trigger_out", trigger_out, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset cfg_err", cfg_err, 0);
    chk("reset pulses_sent", pulses_sent, 0);
    reset_n = 1'b1;
    step();

    // 4 pulses, 3 high / 7 low.
    kick(10, 3, 4, s);
    push_burst(s, 10, 3, 4);
    step();
    start = 1'b0;
    wait_to(s + 39);
    chk("busy last burst cycle", busy, 1);
    wait_to(s + 40);
    chk("busy after burst", busy, 0);
    chk("pulses_sent after burst", pulses_sent, 4);
    step();

    // Minimum pulse, then a restart in the done cycle.
    kick(2, 1, 1, s);
    push_burst(s, 2, 1, 1);
    step();
    start = 1'b0;
    wait_to(s + 2);
    kick(2, 1, 1, s2);
    chk("restart start cycle", s2, s + 3);
    push_burst(s2, 2, 1, 1);
    step();
    start = 1'b0;
    wait_to(s2 + 3);

    // Rejected configurations.
    foreach (cfg_tab[i]) begin
      kick(cfg_tab[i][0], cfg_tab[i][1], 2, s);
      push(EV_CFG, s, 1);
      step();
      start = 1'b0;
      chk("busy after bad cfg", busy, 0);
      chk("trigger after bad cfg", trigger_out, 0);
      step();
      chk("cfg_err one cycle", cfg_err, 0);
    end

    // Continuous mode, config change mid-burst, abort in the 11th high phase.
    kick(4, 2, 0, s);
    for (int i = 0; i < 11; i++) begin
      push(EV_RISE, s + i * 4, i + 1);
      if (i < 10) push(EV_FALL, s + i * 4 + 2, i + 1);
    end
    push(EV_FALL, s + 41, 11);
    step();
    start = 1'b0;
    wait_to(s + 5);
    period    = CNT_W'(7);
    high_time = CNT_W'(1);
    wait_to(s + 40);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("busy after abort", busy, 0);
    chk("pulses_sent after abort", pulses_sent, 11);
    repeat (6) step();

    // start and abort together in IDLE: nothing happens.
    period     = CNT_W'(10);
    high_time  = CNT_W'(3);
    num_pulses = CNT_W'(1);
    start      = 1'b1;
    abort      = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("busy start+abort", busy, 0);
    chk("pulses_sent start+abort", pulses_sent, 11);
    repeat (3) step();

    // start re-pulsed during a burst is ignored.
    kick(6, 2, 2, s);
    push_burst(s, 6, 2, 2);
    step();
    start = 1'b0;
    wait_to(s + 3);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_to(s + 8);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_to(s + 12);
    chk("busy after re-pulsed burst", busy, 0);
    repeat (3) step();

    // Asynchronous reset in the middle of a HIGH phase.
    kick(10, 6, 3, s);
    push(EV_RISE, s, 1);
    step();
    start = 1'b0;
    wait_to(s + 2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset trigger_out", trigger_out, 0);
    chk("async reset busy", busy, 0);
    chk("async reset pulses_sent", pulses_sent, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("events left at reset", exp_q.size(), 0);
    exp_q.delete();

    // Normal operation after reset.
    kick(4, 1, 2, s);
    push_burst(s, 4, 1, 2);
    step();
    start = 1'b0;
    wait_to(s + 9);
    chk("pulses_sent after reset burst", pulses_sent, 2);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    chk("events never seen", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
